// File: rtl/dpram_be_ctl_if.sv
// ---------------------------------------------------------------------------
// dpram_be_ctl_if
// Request/response bundle for the byte-enabled dual-port RAM controller.
//
// Ports (signals):
//   wEnbA   : port A write enable
//   bEnbA   : port A byte enables, bit i covers wDataA[i*BYTEW +: BYTEW]
//   addrA   : port A address (shared by port A read and write)
//   wDataA  : port A write data, full width
//   rEnbA   : port A read request
//   rDataA  : port A read data
//   rVldA   : rDataA valid, one pulse per request
//   rEnbB   : port B read request
//   rAddrB  : port B read address
//   rDataB  : port B read data
//   rVldB   : rDataB valid, one pulse per request
//   busy    : zero-clear sweep in progress, requests are ignored
//
// master drives requests and samples responses; slave is the RAM controller.
// ---------------------------------------------------------------------------
interface dpram_be_ctl_if #(
  parameter int DATAW = 90,
  parameter int BYTEW = 9,
  parameter int AW    = 10
);
  localparam int NB = DATAW / BYTEW;

  logic             wEnbA;
  logic [NB-1:0]    bEnbA;
  logic [AW-1:0]    addrA;
  logic [DATAW-1:0] wDataA;
  logic             rEnbA;
  logic [DATAW-1:0] rDataA;
  logic             rVldA;
  logic             rEnbB;
  logic [AW-1:0]    rAddrB;
  logic [DATAW-1:0] rDataB;
  logic             rVldB;
  logic             busy;

  modport master (
    output wEnbA, bEnbA, addrA, wDataA, rEnbA, rEnbB, rAddrB,
    input  rDataA, rVldA, rDataB, rVldB, busy
  );

  modport slave (
    input  wEnbA, bEnbA, addrA, wDataA, rEnbA, rEnbB, rAddrB,
    output rDataA, rVldA, rDataB, rVldB, busy
  );
endinterface

// File: rtl/dpram_be_ctl.sv
// ---------------------------------------------------------------------------
// dpram_be_ctl
// Byte-enabled dual-port RAM core. Port A reads and writes (per-byte
// enables), port B is read-only. Reads are pipelined (RLAT = 1 or 2) with
// valid flags, port A writes are forwarded into same-cycle reads, addresses
// beyond MEMD are harmless (writes dropped, reads return zero), and after
// reset an optional sweep clears every word to zero.
//
// Ports:
//   clk : clock
//   rst : synchronous reset, active low
//   bus : dpram_be_ctl_if.slave -- request inputs, read data/valid, busy
// ---------------------------------------------------------------------------
module dpram_be_ctl #(
  parameter int MEMD   = 1024,
  parameter int DATAW  = 90,
  parameter int BYTEW  = 9,
  parameter int RLAT   = 1,
  parameter int BYPASS = 1,
  parameter int IZERO  = 1
) (
  input logic           clk,
  input logic           rst,
  dpram_be_ctl_if.slave bus
);
  localparam int NB = DATAW / BYTEW;
  localparam int AW = $clog2(MEMD);
  // One extra bit so that a power-of-two depth is representable.
  localparam logic [AW:0]   DEPTH = (AW+1)'(MEMD);
  localparam logic [AW-1:0] LAST  = AW'(MEMD - 1);

  // ---------------------------------------------------------------- FSM --
  typedef enum logic {CLEAR, READY} stateT;

  stateT         stateReg;
  logic [AW-1:0] cntReg;
  logic          busyReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cntReg   <= '0;
      stateReg <= (IZERO != 0) ? CLEAR : READY;
      busyReg  <= (IZERO != 0);
    end else begin
      case (stateReg)
        CLEAR: begin
          // The edge that writes the last word also drops busy.
          if (cntReg == LAST) begin
            stateReg <= READY;
            busyReg  <= 1'b0;
          end else begin
            cntReg <= cntReg + AW'(1);
          end
        end
        default: busyReg <= 1'b0;
      endcase
    end
  end

  logic ready;
  assign ready = (stateReg == READY);

  // ------------------------------------------------- write port select --
  logic          inRangeA, inRangeB, wrHit;
  logic          memWe;
  logic [AW-1:0] memAddr, rdIdxA, rdIdxB;
  logic [DATAW-1:0] memData;
  logic [NB-1:0] memBe;

  assign inRangeA = {1'b0, bus.addrA}  < DEPTH;
  assign inRangeB = {1'b0, bus.rAddrB} < DEPTH;
  assign wrHit    = ready && bus.wEnbA && inRangeA;

  // The sweep owns the write port while clearing; nothing is written
  // on an edge where reset is asserted.
  assign memWe   = rst && (!ready || wrHit);
  assign memAddr = ready ? bus.addrA  : cntReg;
  assign memData = ready ? bus.wDataA : '0;
  assign memBe   = ready ? bus.bEnbA  : '1;

  // Out-of-range reads are steered to word 0 so the array is never indexed
  // past its end; the result is forced to zero further down.
  assign rdIdxA = inRangeA ? bus.addrA  : '0;
  assign rdIdxB = inRangeB ? bus.rAddrB : '0;

  // ------------------------------------------- stage 0 request tracking --
  logic             vld0A, vld0B, oor0A, oor0B, hit0A, hit0B;
  logic [DATAW-1:0] fwdData;
  logic [NB-1:0]    fwdBe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld0A   <= 1'b0;
      vld0B   <= 1'b0;
      oor0A   <= 1'b0;
      oor0B   <= 1'b0;
      hit0A   <= 1'b0;
      hit0B   <= 1'b0;
      fwdData <= '0;
      fwdBe   <= '0;
    end else begin
      vld0A   <= ready && bus.rEnbA;
      vld0B   <= ready && bus.rEnbB;
      oor0A   <= !inRangeA;
      oor0B   <= !inRangeB;
      // Port A always reads the address it writes.
      hit0A   <= wrHit;
      hit0B   <= (BYPASS != 0) && wrHit && (bus.rAddrB == bus.addrA);
      fwdData <= bus.wDataA;
      fwdBe   <= bus.bEnbA;
    end
  end

  // --------------------------------------- byte-lane RAMs + forwarding --
  // Each byte lane is its own read-first array, so a colliding read
  // returns the old lane and the forwarding mux substitutes written lanes.
  logic [DATAW-1:0] mergA, mergB, dataA0, dataB0;

  for (genvar gi = 0; gi < NB; gi++) begin : gLane
    logic [BYTEW-1:0] lane [MEMD];
    logic [BYTEW-1:0] qA, qB;

    always_ff @(posedge clk) begin
      if (memWe && memBe[gi])
        lane[memAddr] <= memData[gi*BYTEW +: BYTEW];
      if (bus.rEnbA)
        qA <= lane[rdIdxA];
      if (bus.rEnbB)
        qB <= lane[rdIdxB];
    end

    assign mergA[gi*BYTEW +: BYTEW] = (hit0A && fwdBe[gi]) ?
                                      fwdData[gi*BYTEW +: BYTEW] : qA;
    assign mergB[gi*BYTEW +: BYTEW] = (hit0B && fwdBe[gi]) ?
                                      fwdData[gi*BYTEW +: BYTEW] : qB;
  end

  assign dataA0 = oor0A ? '0 : mergA;
  assign dataB0 = oor0B ? '0 : mergB;

  // ------------------------------------------- optional extra stage --
  logic             vldA1, vldB1;
  logic [DATAW-1:0] dataA1, dataB1;

  if (RLAT == 2) begin : gStage2
    logic             s1VldA, s1VldB;
    logic [DATAW-1:0] s1DataA, s1DataB;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1VldA  <= 1'b0;
        s1VldB  <= 1'b0;
        s1DataA <= '0;
        s1DataB <= '0;
      end else begin
        s1VldA <= vld0A;
        s1VldB <= vld0B;
        if (vld0A) s1DataA <= dataA0;
        if (vld0B) s1DataB <= dataB0;
      end
    end

    assign vldA1  = s1VldA;
    assign vldB1  = s1VldB;
    assign dataA1 = s1DataA;
    assign dataB1 = s1DataB;
  end else begin : gStage1
    assign vldA1  = vld0A;
    assign vldB1  = vld0B;
    assign dataA1 = dataA0;
    assign dataB1 = dataB0;
  end

  // ------------------------------------------------ output registers --
  logic             rVldAReg, rVldBReg;
  logic [DATAW-1:0] rDataAReg, rDataBReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rVldAReg  <= 1'b0;
      rVldBReg  <= 1'b0;
      rDataAReg <= '0;
      rDataBReg <= '0;
    end else begin
      rVldAReg <= vldA1;
      rVldBReg <= vldB1;
      // Data holds between results.
      if (vldA1) rDataAReg <= dataA1;
      if (vldB1) rDataBReg <= dataB1;
    end
  end

  assign bus.rDataA = rDataAReg;
  assign bus.rVldA  = rVldAReg;
  assign bus.rDataB = rDataBReg;
  assign bus.rVldB  = rVldBReg;
  assign bus.busy   = busyReg;
endmodule

// File: tb/tb_dpram_be_ctl.sv
// ---------------------------------------------------------------------------
// tb_dpram_be_ctl
// Two controllers share one stimulus stream:
//   dut0: MEMD=16, RLAT=1, BYPASS=1, IZERO=1
//   dut1: MEMD=12, RLAT=2, BYPASS=0, IZERO=1
// A word-level model (array memory, sweep countdown, per-port delay line)
// predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_dpram_be_ctl;
  localparam int NDUT = 2;
  localparam int MD [NDUT] = '{16, 12};
  localparam int RL [NDUT] = '{1, 2};
  localparam int BP [NDUT] = '{1, 0};

  typedef struct packed {
    logic        v;
    logic [35:0] d;
  } resT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wEnbA, rEnbA, rEnbB;
  logic [3:0]  bEnbA, addrA, rAddrB;
  logic [35:0] wDataA;

  dpram_be_ctl_if #(.DATAW(36), .BYTEW(9), .AW(4)) ifc0 ();
  dpram_be_ctl_if #(.DATAW(36), .BYTEW(9), .AW(4)) ifc1 ();

  assign ifc0.wEnbA  = wEnbA;   assign ifc1.wEnbA  = wEnbA;
  assign ifc0.bEnbA  = bEnbA;   assign ifc1.bEnbA  = bEnbA;
  assign ifc0.addrA  = addrA;   assign ifc1.addrA  = addrA;
  assign ifc0.wDataA = wDataA;  assign ifc1.wDataA = wDataA;
  assign ifc0.rEnbA  = rEnbA;   assign ifc1.rEnbA  = rEnbA;
  assign ifc0.rEnbB  = rEnbB;   assign ifc1.rEnbB  = rEnbB;
  assign ifc0.rAddrB = rAddrB;  assign ifc1.rAddrB = rAddrB;

  dpram_be_ctl #(.MEMD(16), .DATAW(36), .BYTEW(9), .RLAT(1), .BYPASS(1), .IZERO(1))
    dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  dpram_be_ctl #(.MEMD(12), .DATAW(36), .BYTEW(9), .RLAT(2), .BYPASS(0), .IZERO(1))
    dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

  logic [35:0] oDA [NDUT], oDB [NDUT];
  logic        oVA [NDUT], oVB [NDUT], oBusy [NDUT];
  assign oDA[0] = ifc0.rDataA;  assign oDA[1] = ifc1.rDataA;
  assign oDB[0] = ifc0.rDataB;  assign oDB[1] = ifc1.rDataB;
  assign oVA[0] = ifc0.rVldA;   assign oVA[1] = ifc1.rVldA;
  assign oVB[0] = ifc0.rVldB;   assign oVB[1] = ifc1.rVldB;
  assign oBusy[0] = ifc0.busy;  assign oBusy[1] = ifc1.busy;

  // ------------------------------------------------------------ model --
  logic [35:0] mdl [NDUT][16];
  int          sweep [NDUT];
  resT         hA [NDUT][2], hB [NDUT][2];
  logic        eVA [NDUT], eVB [NDUT];
  logic [35:0] eDA [NDUT], eDB [NDUT];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [35:0] applyWr(input logic [35:0] old,
                                          input logic [35:0] d,
                                          input logic [3:0]  be);
    logic [35:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (be[i]) m = m | (36'h1FF << (9 * i));
    return (old & ~m) | (d & m);
  endfunction

  task automatic modelEdge(input int k);
    resT         outA, outB, newA, newB;
    logic [35:0] wrWord;
    bit          busyNow, wrOk;
    if (!rst) begin
      sweep[k] = MD[k];
      for (int d = 0; d < 2; d++) begin
        hA[k][d] = '0;
        hB[k][d] = '0;
      end
      eVA[k] = 1'b0;  eVB[k] = 1'b0;
      eDA[k] = '0;    eDB[k] = '0;
    end else begin
      busyNow = sweep[k] > 0;
      outA = hA[k][RL[k]-1];
      outB = hB[k][RL[k]-1];
      eVA[k] = outA.v;
      eVB[k] = outB.v;
      if (outA.v) eDA[k] = outA.d;
      if (outB.v) eDB[k] = outB.d;

      wrOk   = !busyNow && wEnbA && (int'(addrA) < MD[k]);
      wrWord = wrOk ? applyWr(mdl[k][addrA], wDataA, bEnbA) : '0;

      newA.v = !busyNow && rEnbA;
      if (int'(addrA) >= MD[k]) newA.d = '0;
      else if (wrOk)            newA.d = wrWord;
      else                      newA.d = mdl[k][addrA];

      newB.v = !busyNow && rEnbB;
      if (int'(rAddrB) >= MD[k])                   newB.d = '0;
      else if (wrOk && rAddrB == addrA && BP[k] != 0) newB.d = wrWord;
      else                                          newB.d = mdl[k][rAddrB];

      hA[k][1] = hA[k][0];  hA[k][0] = newA;
      hB[k][1] = hB[k][0];  hB[k][0] = newB;

      if (busyNow) begin
        mdl[k][MD[k] - sweep[k]] = '0;
        sweep[k]--;
      end else if (wrOk) begin
        mdl[k][addrA] = wrWord;
      end
    end
  endtask

  task automatic chk(input string tag, input int k,
                     input logic [35:0] obs, input logic [35:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) modelEdge(k);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("busy",   k, 36'(oBusy[k]), 36'(sweep[k] > 0));
      chk("rVldA",  k, 36'(oVA[k]),   36'(eVA[k]));
      chk("rDataA", k, oDA[k],        eDA[k]);
      chk("rVldB",  k, 36'(oVB[k]),   36'(eVB[k]));
      chk("rDataB", k, oDB[k],        eDB[k]);
    end
  endtask

  task automatic clr();
    wEnbA = 1'b0; bEnbA = 4'h0; addrA = 4'h0; wDataA = '0;
    rEnbA = 1'b0; rEnbB = 1'b0; rAddrB = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence ended");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- sequence --
  initial begin
    logic [35:0] pat [4];
    int n0, n1, guard;

    rst = 1'b0;
    clr();
    step();
    step();
    rst = 1'b1;

    // Seven sweep cycles with a read and a write that must be ignored.
    for (int i = 0; i < 7; i++) begin
      rEnbB = (i == 3); rAddrB = 4'd2;
      wEnbA = (i == 5); addrA = 4'd6; bEnbA = 4'hF; wDataA = 36'h0DEADBEEF;
      step();
    end
    clr();
    rst = 1'b0;
    step();
    rst = 1'b1;

    // Restarted sweep: count busy cycles, poke requests that must be dropped.
    n0 = 0; n1 = 0; guard = 0;
    while ((oBusy[0] || oBusy[1]) && guard < 40) begin
      if (oBusy[0]) n0++;
      if (oBusy[1]) n1++;
      rEnbB = (guard == 4);  rAddrB = 4'(guard);
      rEnbA = (guard == 10); addrA  = 4'd7;
      wEnbA = (guard == 2);  bEnbA = 4'hF; wDataA = 36'h123123123;
      guard++;
      step();
    end
    clr();
    chk("busyCycles", 0, 36'(n0), 36'd16);
    chk("busyCycles", 1, 36'(n1), 36'd12);

    // Read every address on port B: all zero, out-of-range included.
    for (int a = 0; a < 16; a++) begin
      rEnbB = 1'b1; rAddrB = 4'(a);
      step();
    end
    clr();
    step();
    step();

    // Partial write merge on address 3. Byte lanes of 36'h123456789 are
    // {024,0D1,0B3,189}; enabling lanes 0 and 2 gives {024,1FF,0B3,1FF}.
    wEnbA = 1'b1; addrA = 4'd3; wDataA = 36'h123456789; bEnbA = 4'hF;
    step();
    wDataA = 36'hFFFFFFFFF; bEnbA = 4'b0101;
    step();
    clr();
    rEnbA = 1'b1; addrA = 4'd3;
    step();
    clr();
    step();
    chk("merge3", 0, oDA[0], 36'h127FD67FF);
    step();
    chk("merge3", 1, oDA[1], 36'h127FD67FF);

    // Same-cycle write/read collision on address 5.
    wEnbA = 1'b1; addrA = 4'd5; wDataA = 36'hABCDEF012; bEnbA = 4'hF;
    rEnbB = 1'b1; rAddrB = 4'd5;
    step();
    clr();
    step();
    chk("bypassNew", 0, oDB[0], 36'hABCDEF012);
    step();
    chk("bypassOld", 1, oDB[1], 36'h0);

    // Back-to-back port B reads through the two-stage pipeline.
    for (int i = 0; i < 4; i++) begin
      pat[i] = 36'h0A0A0A0A0 + 36'(i * 17);
      wEnbA = 1'b1; addrA = 4'(i); wDataA = pat[i]; bEnbA = 4'hF;
      step();
    end
    clr();
    for (int i = 0; i < 7; i++) begin
      rEnbB = (i < 4); rAddrB = 4'(i);
      step();
      chk("pipeVld", 1, 36'(oVB[1]), 36'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk("pipeData", 1, oDB[1], pat[i-2]);
    end
    clr();

    // Out-of-range write/read on the 12-word instance; word 11 untouched.
    wEnbA = 1'b1; addrA = 4'd11; wDataA = 36'h5A5A5A5A5; bEnbA = 4'hF;
    step();
    addrA = 4'd13; wDataA = 36'hFFFFFFFFF;
    step();
    clr();
    rEnbA = 1'b1; addrA = 4'd13; rEnbB = 1'b1; rAddrB = 4'd13;
    step();
    clr();
    step();
    step();
    chk("oorDataA", 1, oDA[1], 36'h0);
    chk("oorVldA",  1, 36'(oVA[1]), 36'd1);
    chk("oorDataB", 1, oDB[1], 36'h0);
    chk("oorVldB",  1, 36'(oVB[1]), 36'd1);
    rEnbB = 1'b1; rAddrB = 4'd11;
    step();
    clr();
    step();
    step();
    chk("keep11", 1, oDB[1], 36'h5A5A5A5A5);

    // Random traffic with frequent collisions and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(99) != 0);
      wEnbA  = 1'($urandom_range(1));
      bEnbA  = 4'($urandom);
      addrA  = 4'($urandom);
      wDataA = {4'($urandom), $urandom};
      rEnbA  = 1'($urandom_range(1));
      rEnbB  = 1'($urandom_range(1));
      rAddrB = ($urandom_range(3) == 0) ? addrA : 4'($urandom);
      step();
    end
    rst = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
